// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch timekeeping core.
// Holds digit widths, BCD limits, default divider values and a BCD helper.
package stopwatch_pkg;

    localparam int TENS_W = 3;
    localparam int ONES_W = 4;

    localparam logic [ONES_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [TENS_W-1:0] TENS_MAX     = 3'd5;

    localparam int DEF_TICK_DIV  = 100_000_000;
    localparam int DEF_ADJ_DIV   = 50_000_000;
    localparam int DEF_DB_CYCLES = 1_000_000;

    typedef struct packed {
        logic [TENS_W-1:0] tens;
        logic [ONES_W-1:0] ones;
    } bcd_pair_t;

    // True when the pair reads 59, i.e. the next increment carries out.
    function automatic logic bcd_at_max(input bcd_pair_t p);
        return (p.tens == TENS_MAX) && (p.ones == SEC_ONES_MAX);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-sample debouncer.
// Ports: clk, rstN (sync, active-low), i_raw (async button), o_level (debounced).
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rstN,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // The counter tracks consecutive samples that disagree with the output;
    // any agreeing sample restarts it.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch core: dividers, button handling, run/pause/adjust/clear.
// Ports: clk, rstN, pauseBtn, clrBtn, adjIn, selIn in; m10, m1, s10, s1, adj, sel, running out.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ADJ_DIV   = DEF_ADJ_DIV,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              pauseBtn,
    input  logic              clrBtn,
    input  logic              adjIn,
    input  logic              selIn,
    output logic [TENS_W-1:0] m10,
    output logic [ONES_W-1:0] m1,
    output logic [TENS_W-1:0] s10,
    output logic [ONES_W-1:0] s1,
    output logic              adj,
    output logic              sel,
    output logic              running
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);

    function automatic bcd_pair_t bcd_inc(input bcd_pair_t p);
        bcd_pair_t r;
        r = p;
        if (p.ones == SEC_ONES_MAX) begin
            r.ones = '0;
            r.tens = (p.tens == TENS_MAX) ? '0 : p.tens + 3'd1;
        end else begin
            r.ones = p.ones + 4'd1;
        end
        return r;
    endfunction

    logic          r_adj_s1;
    logic          r_adj;
    logic          r_sel_s1;
    logic          r_sel;
    logic [TW-1:0] r_tdiv;
    logic [AW-1:0] r_adiv;
    logic          r_run;
    logic          r_pause_prev;
    bcd_pair_t     r_min;
    bcd_pair_t     r_sec;

    logic      w_pause_lvl;
    logic      w_clr_lvl;
    logic      w_pause_pulse;
    logic      w_tick1;
    logic      w_tick2;
    bcd_pair_t w_min_next;
    bcd_pair_t w_sec_next;
    logic      w_sec_carry;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk     (clk),
        .rstN    (rstN),
        .i_raw   (pauseBtn),
        .o_level (w_pause_lvl)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk     (clk),
        .rstN    (rstN),
        .i_raw   (clrBtn),
        .o_level (w_clr_lvl)
    );

    assign w_pause_pulse = w_pause_lvl & ~r_pause_prev;
    assign w_tick1       = (r_tdiv == TICK_LAST);
    assign w_tick2       = (r_adiv == ADJ_LAST);
    assign w_min_next    = bcd_inc(r_min);
    assign w_sec_next    = bcd_inc(r_sec);
    assign w_sec_carry   = bcd_at_max(r_sec);

    // adj/sel are level switches: synchronized only, no debounce.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_adj_s1 <= 1'b0;
            r_adj    <= 1'b0;
            r_sel_s1 <= 1'b0;
            r_sel    <= 1'b0;
        end else begin
            r_adj_s1 <= adjIn;
            r_adj    <= r_adj_s1;
            r_sel_s1 <= selIn;
            r_sel    <= r_sel_s1;
        end
    end

    // Holding the divider at 0 during clear makes the first second full length.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_tdiv <= '0;
        end else if (w_clr_lvl || w_tick1) begin
            r_tdiv <= '0;
        end else begin
            r_tdiv <= r_tdiv + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_adiv <= '0;
        end else if (!r_adj || w_tick2) begin
            r_adiv <= '0;
        end else begin
            r_adiv <= r_adiv + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_run        <= 1'b0;
            r_pause_prev <= 1'b0;
        end else begin
            r_pause_prev <= w_pause_lvl;
            if (w_pause_pulse) begin
                r_run <= ~r_run;
            end
        end
    end

    // Clear beats adjust beats normal counting.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_min <= '0;
            r_sec <= '0;
        end else if (w_clr_lvl) begin
            r_min <= '0;
            r_sec <= '0;
        end else if (r_adj) begin
            if (w_tick2) begin
                if (r_sel) begin
                    r_sec <= w_sec_next;
                end else begin
                    r_min <= w_min_next;
                end
            end
        end else if (r_run && w_tick1) begin
            r_sec <= w_sec_next;
            if (w_sec_carry) begin
                r_min <= w_min_next;
            end
        end
    end

    assign m10     = r_min.tens;
    assign m1      = r_min.ones;
    assign s10     = r_sec.tens;
    assign s1      = r_sec.ones;
    assign adj     = r_adj;
    assign sel     = r_sel;
    assign running = r_run;

endmodule
